mem_arbiter: RTL

Two-requester arbiter that shares one single-beat memory port between the fetch stage's instruction bus and the memory stage's data bus of the MIPS core. It sits between the CPU pipeline and the external memory interface. It serialises requests with a three-state FSM: round-robin on conflict, one transaction outstanding at a time. It latches each granted request so requesters need not hold their signals after acceptance.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state,
// requester identity and the winner-selection rule.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_owner_t;

    // Round-robin pick: a lone requester wins outright; on a conflict the
    // requester that did not win last time gets the port.
    function automatic arb_owner_t pick_winner(input logic i_v, input logic d_v,
                                               input arb_owner_t last);
        if (i_v && d_v) begin
            return (last == ARB_I) ? ARB_D : ARB_I;
        end else if (d_v) begin
            return ARB_D;
        end else begin
            return ARB_I;
        end
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-beat memory port between the fetch-stage instruction
// bus and the memory-stage data bus. One transaction is outstanding at a
// time; the granted request is latched so requesters may drop it after
// their addr_ok.
//
// Handshake: a requester raises *_valid and holds it until it sees its
// *_addr_ok pulse (combinational, in the IDLE cycle the request is
// sampled). The memory side sees mreq_valid from the cycle after the grant
// until a cycle with mreq_ready high; its single response is one cycle of
// mresp_valid, which is only honoured in WAIT and is returned to the owner
// as a *_data_ok pulse with the data passed straight through.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          ireq_valid,
    input  logic [AW-1:0] ireq_addr,
    output logic          iresp_addr_ok,
    output logic          iresp_data_ok,
    output logic [DW-1:0] iresp_data,
    input  logic          dreq_valid,
    input  logic          dreq_write,
    input  logic [AW-1:0] dreq_addr,
    input  logic [3:0]    dreq_strobe,
    input  logic [DW-1:0] dreq_wdata,
    output logic          dresp_addr_ok,
    output logic          dresp_data_ok,
    output logic [DW-1:0] dresp_data,
    output logic          mreq_valid,
    output logic          mreq_write,
    output logic [AW-1:0] mreq_addr,
    output logic [3:0]    mreq_strobe,
    output logic [DW-1:0] mreq_wdata,
    input  logic          mreq_ready,
    input  logic          mresp_valid,
    input  logic [DW-1:0] mresp_data,
    output logic [1:0]    dbg_state
);

    arb_state_t    state_q;
    arb_owner_t    own_q;
    arb_owner_t    last_q;
    logic          write_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    strobe_q;
    logic [DW-1:0] wdata_q;

    logic          grant_any;
    arb_owner_t    grant_owner;
    logic          rsp_fire;

    // Winner selection and response routing; pulses are suppressed while
    // resetn is low so nothing leaks out during a reset cycle.
    always_comb begin
        grant_any     = 1'b0;
        grant_owner   = ARB_I;
        if (resetn && (state_q == ARB_IDLE) && (ireq_valid || dreq_valid)) begin
            grant_any   = 1'b1;
            grant_owner = pick_winner(ireq_valid, dreq_valid, last_q);
        end
        iresp_addr_ok = grant_any && (grant_owner == ARB_I);
        dresp_addr_ok = grant_any && (grant_owner == ARB_D);
        rsp_fire      = resetn && (state_q == ARB_WAIT) && mresp_valid;
        iresp_data_ok = rsp_fire && (own_q == ARB_I);
        dresp_data_ok = rsp_fire && (own_q == ARB_D);
        iresp_data    = iresp_data_ok ? mresp_data : '0;
        dresp_data    = dresp_data_ok ? mresp_data : '0;
    end

    // Arbitration FSM plus the latched request fields.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ARB_IDLE;
            own_q    <= ARB_I;
            last_q   <= ARB_I;
            write_q  <= 1'b0;
            addr_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant_any) begin
                        state_q <= ARB_REQ;
                        own_q   <= grant_owner;
                        last_q  <= grant_owner;
                        if (grant_owner == ARB_D) begin
                            write_q  <= dreq_write;
                            addr_q   <= dreq_addr;
                            strobe_q <= dreq_strobe;
                            wdata_q  <= dreq_wdata;
                        end else begin
                            write_q  <= 1'b0;
                            addr_q   <= ireq_addr;
                            strobe_q <= 4'b0000;
                            wdata_q  <= '0;
                        end
                    end
                end
                ARB_REQ: begin
                    // A response arriving with the accept is not honoured.
                    if (mreq_ready) begin
                        state_q <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (mresp_valid) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign mreq_valid  = (state_q == ARB_REQ);
    assign mreq_write  = write_q;
    assign mreq_addr   = addr_q;
    assign mreq_strobe = strobe_q;
    assign mreq_wdata  = wdata_q;
    assign dbg_state   = state_q;

endmodule
